// File: rtl/mul_div_unit_if.sv
// Request/response bundle between decode/regfile and the iterative multiply/divide unit.
interface mul_div_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic            sgn;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, op, sgn, a, b, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, op, sgn, a, b, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-cycle shift-add multiplier / restoring divider feeding the register file write port.
// Define MDU_SIGNED_EN to build two's-complement support selected per request by sgn.
module mul_div_unit #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic         clk,
    input  logic         rst,
    mul_div_unit_if.slave mdu
);
    localparam int CW = $clog2(ITERS);

    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      op_r;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] opnd_b;
    logic            busy_r;
    logic            done_r;
    logic [XLEN-1:0] result_r;
    logic [4:0]      rd_r;

    logic [XLEN-1:0] init_a;
    logic [XLEN-1:0] init_b;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] sub;
    logic            ge;
    logic [XLEN-1:0] nxt_hi;
    logic [XLEN-1:0] nxt_lo;
    logic [XLEN-1:0] fin_res;

    assign mdu.busy   = busy_r;
    assign mdu.done   = done_r;
    assign mdu.result = result_r;
    assign mdu.rd_out = rd_r;

    // MUL keeps {product_hi, multiplier} in acc; DIV keeps {remainder, dividend/quotient}.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
        rem_sh  = {acc_hi, acc_lo[XLEN-1]};
        ge      = rem_sh >= {1'b0, opnd_b};
        sub     = rem_sh[XLEN-1:0] - opnd_b;
        nxt_hi  = rem_sh[XLEN-1:0];
        nxt_lo  = {acc_lo[XLEN-2:0], 1'b0};
        if (!op_r[1]) begin
            nxt_hi = mul_sum[XLEN:1];
            nxt_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end else if (ge) begin
            nxt_hi = sub;
            nxt_lo = {acc_lo[XLEN-2:0], 1'b1};
        end
    end

`ifdef MDU_SIGNED_EN
    logic                neg_prod;
    logic                neg_quo;
    logic                neg_rem;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix;
    logic [XLEN-1:0]     rem_fix;

    function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] v, input logic s);
        return (s && v < 0) ? XLEN'(-v) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] fix_wide(input logic [2*XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] fix_word(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign init_a = mag(mdu.a, mdu.sgn);
    assign init_b = mag(mdu.b, mdu.sgn);

    // A zero divisor must still yield all-ones, so the quotient sign flip is suppressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_prod <= 1'b0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (state == IDLE && mdu.start) begin
            neg_prod <= mdu.sgn & (mdu.a[XLEN-1] ^ mdu.b[XLEN-1]);
            neg_quo  <= mdu.sgn & (mdu.a[XLEN-1] ^ mdu.b[XLEN-1]) & (|mdu.b);
            neg_rem  <= mdu.sgn & mdu.a[XLEN-1];
        end
    end

    always_comb begin
        prod_fix = fix_wide({nxt_hi, nxt_lo}, neg_prod);
        quo_fix  = fix_word(nxt_lo, neg_quo);
        rem_fix  = fix_word(nxt_hi, neg_rem);
        case (op_r)
            2'b00:   fin_res = prod_fix[XLEN-1:0];
            2'b01:   fin_res = prod_fix[2*XLEN-1:XLEN];
            2'b10:   fin_res = quo_fix;
            default: fin_res = rem_fix;
        endcase
    end
`else
    logic unused_sgn;

    assign unused_sgn = mdu.sgn;
    assign init_a     = mdu.a;
    assign init_b     = mdu.b;

    always_comb begin
        case (op_r)
            2'b00, 2'b10: fin_res = nxt_lo;
            default:      fin_res = nxt_hi;
        endcase
    end
`endif

    // The final iteration step and sign fix land directly in result_r on the edge entering FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_r     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd_b   <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
            rd_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (mdu.start) begin
                        state  <= ITER;
                        busy_r <= 1'b1;
                        cnt    <= '0;
                        op_r   <= mdu.op;
                        acc_hi <= '0;
                        acc_lo <= init_a;
                        opnd_b <= init_b;
                        rd_r   <= mdu.rd_in;
                    end
                end
                ITER: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(ITERS - 1)) begin
                        state    <= FIN;
                        done_r   <= 1'b1;
                        result_r <= fin_res;
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized ops against an arithmetic model.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst;
    int   asserts = 0;
    int   fails   = 0;

    always #5 clk = ~clk;

    mul_div_unit_if #(.XLEN(32)) bus ();

    mul_div_unit #(.XLEN(32), .ITERS(32)) dut (
        .clk (clk),
        .rst (rst),
        .mdu (bus.slave)
    );

    function automatic logic [31:0] model(input logic [1:0] op, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        bit sg;
`ifdef MDU_SIGNED_EN
        sg = s;
`else
        sg = 1'b0;
`endif
        sa = sg ? longint'($signed(a)) : longint'(a);
        sb = sg ? longint'($signed(b)) : longint'(b);
        p  = 64'(sa * sb);
        case (op)
            2'b00: return p[31:0];
            2'b01: return p[63:32];
            2'b10: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            default: return (b == 0) ? a : 32'(sa % sb);
        endcase
    endfunction

    task automatic do_op(input logic [1:0] op, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         output logic [31:0] res, output logic [4:0] rdo,
                         output int lat, output int nbusy, output int ndone);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.sgn = s; bus.a = a; bus.b = b; bus.rd_in = rd;
        @(negedge clk);
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
        bus.op = 2'($urandom); bus.sgn = 1'($urandom); bus.rd_in = 5'($urandom);
        lat = -1; nbusy = 0; ndone = 0; res = 'x; rdo = 'x;
        for (int k = 0; k < 36; k++) begin
            if (bus.busy) nbusy++;
            if (bus.done) begin
                ndone++;
                if (lat < 0) begin
                    lat = k; res = bus.result; rdo = bus.rd_out;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [31:0] r; logic [4:0] d; int lat, nb, nd, seen;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        asserts++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        asserts++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
        asserts++; if (bus.result !== 32'h0) begin fails++; $display("FAIL reset_result got %h want 0", bus.result); end
        asserts++; if (bus.rd_out !== 5'h0) begin fails++; $display("FAIL reset_rd_out got %h want 0", bus.rd_out); end
        rst = 1'b0;
        do_op(2'b00, 1'b0, 32'd1234, 32'd77, 5'd9, r, d, lat, nb, nd);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd5000; bus.b = 32'd3; bus.rd_in = 5'd12;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        asserts++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midreset_busy got %b want 0", bus.busy); end
        asserts++; if (bus.done !== 1'b0) begin fails++; $display("FAIL midreset_done got %b want 0", bus.done); end
        asserts++; if (bus.result !== 32'h0) begin fails++; $display("FAIL midreset_result got %h want 0", bus.result); end
        asserts++; if (bus.rd_out !== 5'h0) begin fails++; $display("FAIL midreset_rd_out got %h want 0", bus.rd_out); end
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done || bus.busy) seen++;
            @(negedge clk);
        end
        asserts++; if (seen !== 0) begin fails++; $display("FAIL midreset_no_done got %0d active cycles want 0", seen); end
    endtask

    task automatic test_mul();
        logic [31:0] r; logic [4:0] d; int lat, nb, nd;
        do_op(2'b00, 1'b0, 32'd7, 32'd6, 5'd5, r, d, lat, nb, nd);
        asserts++; if (r !== 32'd42) begin fails++; $display("FAIL mul_result got %h want %h", r, 32'd42); end
        asserts++; if (d !== 5'd5) begin fails++; $display("FAIL mul_rd_out got %0d want 5", d); end
        asserts++; if (lat !== 32) begin fails++; $display("FAIL mul_latency got %0d want 32", lat); end
        asserts++; if (nb !== 33) begin fails++; $display("FAIL mul_busy_cycles got %0d want 33", nb); end
        asserts++; if (nd !== 1) begin fails++; $display("FAIL mul_done_pulses got %0d want 1", nd); end
    endtask

    task automatic test_mulh();
        logic [31:0] r, want; logic [4:0] d; int lat, nb, nd;
        do_op(2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, r, d, lat, nb, nd);
        asserts++; if (r !== 32'hFFFF_FFFE) begin fails++; $display("FAIL mulh_unsigned got %h want FFFFFFFE", r); end
`ifdef MDU_SIGNED_EN
        want = 32'h0;
`else
        want = 32'hFFFF_FFFE;
`endif
        do_op(2'b01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, r, d, lat, nb, nd);
        asserts++; if (r !== want) begin fails++; $display("FAIL mulh_sgn got %h want %h", r, want); end
    endtask

    task automatic test_div();
        logic [31:0] r; logic [4:0] d; int lat, nb, nd;
        do_op(2'b10, 1'b0, 32'd100, 32'd7, 5'd1, r, d, lat, nb, nd);
        asserts++; if (r !== 32'd14) begin fails++; $display("FAIL div_quot got %h want %h", r, 32'd14); end
        do_op(2'b11, 1'b0, 32'd100, 32'd7, 5'd1, r, d, lat, nb, nd);
        asserts++; if (r !== 32'd2) begin fails++; $display("FAIL div_rem got %h want %h", r, 32'd2); end
        do_op(2'b10, 1'b0, 32'd100, 32'd0, 5'd0, r, d, lat, nb, nd);
        asserts++; if (r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div0_quot got %h want FFFFFFFF", r); end
        asserts++; if (lat !== 32) begin fails++; $display("FAIL div0_latency got %0d want 32", lat); end
        asserts++; if (d !== 5'd0 || nd !== 1) begin fails++; $display("FAIL rd0_write got rd %0d pulses %0d want rd 0 pulses 1", d, nd); end
        do_op(2'b11, 1'b0, 32'd100, 32'd0, 5'd4, r, d, lat, nb, nd);
        asserts++; if (r !== 32'd100) begin fails++; $display("FAIL div0_rem got %h want %h", r, 32'd100); end
    endtask

    task automatic test_signed();
        logic [31:0] r; logic [4:0] d; int lat, nb, nd;
`ifdef MDU_SIGNED_EN
        do_op(2'b10, 1'b1, -32'sd100, 32'd7, 5'd2, r, d, lat, nb, nd);
        asserts++; if (r !== -32'sd14) begin fails++; $display("FAIL sdiv_quot got %h want %h", r, -32'sd14); end
        do_op(2'b11, 1'b1, -32'sd100, 32'd7, 5'd2, r, d, lat, nb, nd);
        asserts++; if (r !== -32'sd2) begin fails++; $display("FAIL sdiv_rem got %h want %h", r, -32'sd2); end
        do_op(2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, r, d, lat, nb, nd);
        asserts++; if (r !== 32'h8000_0000) begin fails++; $display("FAIL sdiv_ovf_quot got %h want 80000000", r); end
        do_op(2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, r, d, lat, nb, nd);
        asserts++; if (r !== 32'h0) begin fails++; $display("FAIL sdiv_ovf_rem got %h want 0", r); end
        do_op(2'b10, 1'b1, -32'sd5, 32'd0, 5'd2, r, d, lat, nb, nd);
        asserts++; if (r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sdiv0_quot got %h want FFFFFFFF", r); end
        do_op(2'b11, 1'b1, -32'sd5, 32'd0, 5'd2, r, d, lat, nb, nd);
        asserts++; if (r !== -32'sd5) begin fails++; $display("FAIL sdiv0_rem got %h want %h", r, -32'sd5); end
`else
        do_op(2'b10, 1'b1, -32'sd100, 32'd7, 5'd2, r, d, lat, nb, nd);
        asserts++; if (r !== 32'd613566742) begin fails++; $display("FAIL sgn_ignored_quot got %h want %h", r, 32'd613566742); end
        do_op(2'b11, 1'b1, -32'sd100, 32'd7, 5'd2, r, d, lat, nb, nd);
        asserts++; if (r !== 32'd2) begin fails++; $display("FAIL sgn_ignored_rem got %h want 2", r); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] r, a, b, want; logic [4:0] d, rd; logic [1:0] op; logic s;
        int lat, nb, nd;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3)); s = 1'($urandom); a = $urandom; rd = 5'($urandom);
            case ($urandom_range(0, 4))
                0:       b = 32'h0;
                1:       b = $urandom_range(1, 15);
                2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            want = model(op, s, a, b);
            do_op(op, s, a, b, rd, r, d, lat, nb, nd);
            asserts++;
            if (r !== want || d !== rd || lat !== 32 || nd !== 1) begin
                fails++;
                $display("FAIL random op=%0d sgn=%0d a=%h b=%h got %h rd %0d lat %0d pulses %0d want %h rd %0d lat 32 pulses 1",
                         op, s, a, b, r, d, lat, nd, want, rd);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t[2]; logic [31:0] res[2]; int nd;
        t[0] = -1; t[1] = -1; res[0] = 'x; res[1] = 'x; nd = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.sgn = 1'b0; bus.a = 32'd3; bus.b = 32'd3; bus.rd_in = 5'd7;
        @(negedge clk);
        for (int k = 0; k < 80; k++) begin
            if (k == 5) bus.a = 32'd9;
            if (bus.done) begin
                if (nd < 2) begin t[nd] = k; res[nd] = bus.result; end
                nd++;
                if (nd == 2) bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        asserts++; if (res[0] !== 32'd9) begin fails++; $display("FAIL b2b_first_result got %h want 9", res[0]); end
        asserts++; if (res[1] !== 32'd27) begin fails++; $display("FAIL b2b_second_result got %h want %h", res[1], 32'd27); end
        asserts++; if (t[0] !== 32 || t[1] !== 66) begin fails++; $display("FAIL b2b_timing got %0d,%0d want 32,66", t[0], t[1]); end
        asserts++; if (nd !== 2) begin fails++; $display("FAIL b2b_done_count got %0d want 2", nd); end
        asserts++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL b2b_idle_after got busy %b want 0", bus.busy); end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.sgn = 1'b0; bus.a = '0; bus.b = '0; bus.rd_in = '0;
        rst = 1'b1;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_signed();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
